// File: rtl/rrx_axi_pkg.sv
// Shared AXI read constants and FSM encoding for the command-stream DMA.
package rrx_axi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [12:0] BOUNDARY_4K = 13'h1000;

    typedef logic [1:0] axi_resp_t;

    function automatic logic resp_is_error(input axi_resp_t resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/cmd_stream_dma_if.sv
// AXI4 read channels plus the command stream, bundled for the DMA and its bus/sink.
interface cmd_stream_dma_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic                  m_cmd_axis_tvalid;
    logic                  m_cmd_axis_tlast;
    logic [DATA_WIDTH-1:0] m_cmd_axis_tdata;
    logic                  m_cmd_axis_tready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata,
        input  m_cmd_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_cmd_axis_tvalid, m_cmd_axis_tlast, m_cmd_axis_tdata,
        output m_cmd_axis_tready
    );
endinterface

// File: rtl/cmd_dma_skid.sv
// Two-entry skid buffer; valid and ready are both driven straight from flops.
module cmd_dma_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       cnt_r;
    logic [1:0]       cnt_nxt_s;
    logic             ready_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = in_valid & ready_r;
    assign pop_s     = valid_r & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = cnt_r - 2'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage, pointers and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r   <= cnt_nxt_s;
            ready_r <= (cnt_nxt_s != 2'd2);
            valid_r <= (cnt_nxt_s != 2'd0);
        end
    end
endmodule

// File: rtl/cmd_stream_dma.sv
// Fetches a word buffer over AXI4 read bursts and replays it as a command stream.
module cmd_stream_dma
    import rrx_axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 25,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [LEN_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    cmd_stream_dma_if.master      bus
);
    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          SIZE_LOG2 = $clog2(BYTES);
    localparam logic [31:0] MAX_BEATS = 32'(MAX_BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic                  busy_r;
    logic                  error_r;
    logic                  zero_done_r;

    logic [12:0]           bound_words_s;
    logic [31:0]           rem_s;
    logic [31:0]           cap_s;
    logic [31:0]           beats_s;
    logic                  start_acc_s;
    logic                  ar_fire_s;
    logic                  r_fire_s;
    logic                  final_fire_s;
    logic                  last_beat_s;
    logic                  skid_in_valid_s;
    logic                  skid_in_ready_s;
    logic                  skid_out_valid_s;
    logic [DATA_WIDTH:0]   skid_out_data_s;
    logic                  unused_s;

    // Burst size: bounded by what is left, the burst cap and the next 4 KiB line.
    assign bound_words_s = (BOUNDARY_4K - {1'b0, addr_r[11:0]}) >> SIZE_LOG2;
    assign rem_s         = 32'(remaining_r);
    assign cap_s         = (rem_s > MAX_BEATS) ? MAX_BEATS : rem_s;
    assign beats_s       = (cap_s > 32'(bound_words_s)) ? 32'(bound_words_s) : cap_s;

    assign start_acc_s     = start & (state_r == ST_IDLE) & ~busy_r;
    assign ar_fire_s       = (state_r == ST_ADDR) & bus.m_axi_arready;
    assign skid_in_valid_s = bus.m_axi_rvalid & (state_r == ST_DATA);
    assign r_fire_s        = skid_in_valid_s & skid_in_ready_s;
    // remaining_r is already net of the current burst, so zero here marks the final word.
    assign last_beat_s     = bus.m_axi_rlast & (remaining_r == {LEN_WIDTH{1'b0}});
    assign final_fire_s    = skid_out_valid_s & bus.m_cmd_axis_tready & skid_out_data_s[DATA_WIDTH];

    assign bus.m_axi_arid    = {ID_WIDTH{1'b0}};
    assign bus.m_axi_araddr  = addr_r;
    assign bus.m_axi_arlen   = beats_s[7:0] - 8'd1;
    assign bus.m_axi_arsize  = 3'(SIZE_LOG2);
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'd0;
    assign bus.m_axi_arprot  = 3'd0;
    assign bus.m_axi_arvalid = (state_r == ST_ADDR);
    assign bus.m_axi_rready  = (state_r == ST_DATA) & skid_in_ready_s;

    assign bus.m_cmd_axis_tvalid = skid_out_valid_s;
    assign bus.m_cmd_axis_tlast  = skid_out_data_s[DATA_WIDTH];
    assign bus.m_cmd_axis_tdata  = skid_out_data_s[DATA_WIDTH-1:0];

    assign busy     = busy_r & ~final_fire_s;
    assign done     = zero_done_r | final_fire_s;
    assign error    = error_r;
    assign unused_s = ^bus.m_axi_rid;

    cmd_dma_skid #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (aclk),
        .rst_n    (resetn),
        .in_valid (skid_in_valid_s),
        .in_ready (skid_in_ready_s),
        .in_data  ({last_beat_s, bus.m_axi_rdata}),
        .out_valid(skid_out_valid_s),
        .out_ready(bus.m_cmd_axis_tready),
        .out_data (skid_out_data_s)
    );

    // Burst sequencer: one outstanding AR at a time.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {LEN_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s && (word_count != {LEN_WIDTH{1'b0}})) begin
                        addr_r      <= src_addr & ALIGN_MASK;
                        remaining_r <= word_count;
                        state_r     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_fire_s) begin
                        addr_r      <= addr_r + ADDR_WIDTH'(beats_s << SIZE_LOG2);
                        remaining_r <= remaining_r - LEN_WIDTH'(beats_s);
                        state_r     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire_s && bus.m_axi_rlast) begin
                        state_r <= (remaining_r != {LEN_WIDTH{1'b0}}) ? ST_ADDR : ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Transfer status: busy spans until the final stream word drains from the skid.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
            zero_done_r <= 1'b0;
        end else begin
            zero_done_r <= start_acc_s & (word_count == {LEN_WIDTH{1'b0}});
            if (start_acc_s && (word_count != {LEN_WIDTH{1'b0}})) begin
                busy_r <= 1'b1;
            end else if (final_fire_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (start_acc_s) begin
                error_r <= 1'b0;
            end else if (r_fire_s && resp_is_error(bus.m_axi_rresp)) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end
endmodule

// File: tb/tb_cmd_stream_dma.sv
// Randomized scoreboard bench: AXI read slave model plus stream monitor against a transfer-level reference.
module tb_cmd_stream_dma;
    localparam int DW = 32, AW = 25, IW = 8, MBL = 16, LW = 16;

    logic          aclk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [LW-1:0] word_count = '0;
    logic          busy, done, error;

    cmd_stream_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    cmd_stream_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                     .MAX_BURST_LEN(MBL), .LEN_WIDTH(LW)) dut (
        .aclk(aclk), .resetn(resetn), .start(start), .src_addr(src_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .bus(bus.master));

    always #5 aclk = ~aclk;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic last; } wd_t;

    ar_t exp_ar_q[$];
    wd_t exp_w_q[$];
    int  checks = 0, errors = 0;
    int  cyc = 0;
    int  tr_mode = 1, ar_rate = 100, r_rate = 100;
    int  err_beat = -1, beat_idx = 0;
    int  r_hs_cnt = 0, s_hs_cnt = 0, w_idx = 0, first_t = 0, last_t = 0;
    bit  r_pending = 0, err_pend = 0, xfer_done = 0, zero_expect = 0, prev_stall = 0;
    logic [DW:0]   prev_w;
    logic [AW-1:0] s_addr;
    int            s_left = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return ({7'h35, a} * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: burst split and word sequence straight from the transfer rules.
    task automatic build_expect(input logic [AW-1:0] addr, input int wc);
        logic [AW-1:0] a, w;
        int rem, to_b, b;
        a = {addr[AW-1:2], 2'b00};
        w = a;
        rem = wc;
        while (rem > 0) begin
            to_b = (4096 - int'(a % 4096)) / 4;
            b = rem;
            if (b > MBL) b = MBL;
            if (b > to_b) b = to_b;
            exp_ar_q.push_back('{a, 8'(b - 1)});
            a = a + AW'(4 * b);
            rem -= b;
        end
        for (int i = 0; i < wc; i++) begin
            exp_w_q.push_back('{memf(w), (i == wc - 1)});
            w = w + AW'(4);
        end
    endtask

    // AXI read slave: R decided before AR so a new burst starts next cycle.
    always begin
        @(negedge aclk);
        if (!resetn) begin
            bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
            bus.m_axi_rresp = 2'd0; bus.m_axi_rdata = '0; bus.m_axi_rid = '0;
            s_left = 0; r_pending = 0; err_pend = 0; r_hs_cnt = 0;
        end else begin
            if (err_pend) begin
                chk("error_set_after_bad_beat", error, 1'b1);
                err_pend = 0;
            end
            r_pending = 0;
            if (s_left > 0) begin
                if (!bus.m_axi_rvalid) bus.m_axi_rvalid = ($urandom_range(99) < r_rate);
                if (bus.m_axi_rvalid) begin
                    bus.m_axi_rdata = memf(s_addr);
                    bus.m_axi_rresp = (beat_idx == err_beat) ? 2'd2 : 2'd0;
                    bus.m_axi_rlast = (s_left == 1);
                    if (bus.m_axi_rready) begin
                        r_pending = 1; r_hs_cnt++;
                        if (beat_idx == err_beat) begin
                            chk("error_clear_before_bad_beat", error, 1'b0);
                            err_pend = 1;
                        end
                        beat_idx++; s_addr = s_addr + AW'(4); s_left--;
                    end
                end
            end else begin
                bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'd0;
            end
            bus.m_axi_arready = (s_left == 0) && ($urandom_range(99) < ar_rate);
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                chk("ar_const", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                                 bus.m_axi_arcache, bus.m_axi_arprot},
                    {8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0});
                if (exp_ar_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ar actual=%0h required=none", bus.m_axi_araddr);
                end else begin
                    ar_t e;
                    e = exp_ar_q.pop_front();
                    chk("ar_addr", bus.m_axi_araddr, e.addr);
                    chk("ar_len", bus.m_axi_arlen, e.len);
                end
                s_addr = bus.m_axi_araddr;
                s_left = int'(bus.m_axi_arlen) + 1;
            end
        end
    end

    // Stream sink and monitor: pops the expected word on each accepted beat.
    always begin
        @(negedge aclk);
        if (!resetn) begin
            bus.m_cmd_axis_tready = 1'b0; prev_stall = 0; s_hs_cnt = 0;
        end else begin
            case (tr_mode)
                0:       bus.m_cmd_axis_tready = 1'($urandom_range(1));
                1:       bus.m_cmd_axis_tready = 1'b1;
                default: bus.m_cmd_axis_tready = ~bus.m_cmd_axis_tready;
            endcase
            #1;
            if (prev_stall)
                chk("stall_hold", {bus.m_cmd_axis_tvalid, bus.m_cmd_axis_tlast, bus.m_cmd_axis_tdata},
                    {1'b1, prev_w});
            if (r_hs_cnt - int'(r_pending) - s_hs_cnt >= 2)
                chk("rready_low_when_full", bus.m_axi_rready, 1'b0);
            if (bus.m_cmd_axis_tvalid && bus.m_cmd_axis_tready) begin
                s_hs_cnt++;
                if (exp_w_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word actual=%0h required=none", bus.m_cmd_axis_tdata);
                end else begin
                    wd_t w;
                    w = exp_w_q.pop_front();
                    chk("tdata", bus.m_cmd_axis_tdata, w.data);
                    chk("tlast", bus.m_cmd_axis_tlast, w.last);
                    chk("done_on_word", done, w.last);
                    chk("busy_on_word", busy, !w.last);
                    if (w_idx == 0) first_t = cyc;
                    w_idx++;
                    if (w.last) begin last_t = cyc; xfer_done = 1; end
                end
            end else if (done && !zero_expect) begin
                errors++;
                $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
            end
            prev_stall = bus.m_cmd_axis_tvalid && !bus.m_cmd_axis_tready;
            prev_w = {bus.m_cmd_axis_tlast, bus.m_cmd_axis_tdata};
        end
    end

    task automatic run_xfer(input logic [AW-1:0] addr, input int wc, input int eb,
                            input bit thru, input bit poke);
        int i;
        build_expect(addr, wc);
        err_beat = eb; beat_idx = 0; xfer_done = 0; w_idx = 0;
        @(negedge aclk);
        start = 1'b1; src_addr = addr; word_count = LW'(wc);
        if (wc == 0) zero_expect = 1;
        @(negedge aclk);
        start = 1'b0;
        #1;
        chk("error_after_start", error, 1'b0);
        if (wc == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_busy", busy, 1'b0);
            chk("zero_arvalid", bus.m_axi_arvalid, 1'b0);
            @(negedge aclk); #1;
            chk("zero_done_one_cycle", done, 1'b0);
            chk("zero_no_ar", bus.m_axi_arvalid, 1'b0);
            #1 zero_expect = 0;
            return;
        end
        chk("busy_after_start", busy, 1'b1);
        if (poke) begin
            repeat (3) @(negedge aclk);
            start = 1'b1; src_addr = AW'(32'h800); word_count = LW'(3);
            @(negedge aclk);
            start = 1'b0;
        end
        for (i = 0; i < 1500 && !xfer_done; i++) @(negedge aclk);
        if (!xfer_done) begin
            errors++;
            $display("FAIL xfer_timeout actual=%0d words required=%0d", w_idx, wc);
        end
        @(negedge aclk); #1;
        chk("busy_after_done", busy, 1'b0);
        chk("ar_queue_drained", exp_ar_q.size(), 0);
        chk("word_queue_drained", exp_w_q.size(), 0);
        chk("error_flag", error, (eb >= 0 && eb < wc));
        if (thru) chk("burst_throughput", last_t - first_t, wc - 1);
        exp_ar_q.delete(); exp_w_q.delete();
    endtask

    task automatic reset_mid_burst();
        build_expect(AW'(32'h2000), 40);
        @(negedge aclk);
        start = 1'b1; src_addr = AW'(32'h2000); word_count = LW'(40);
        @(negedge aclk);
        start = 1'b0;
        repeat (12) @(negedge aclk);
        resetn = 1'b0;
        #1;
        chk("reset_outputs", {bus.m_axi_arvalid, bus.m_axi_rready, bus.m_cmd_axis_tvalid,
                              bus.m_cmd_axis_tlast, busy, done, error}, 7'd0);
        exp_ar_q.delete(); exp_w_q.delete();
        repeat (3) @(negedge aclk);
        resetn = 1'b1;
        repeat (20) @(negedge aclk);
        #1;
        chk("idle_after_reset", {busy, bus.m_cmd_axis_tvalid, bus.m_axi_arvalid}, 3'd0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge aclk);
        #1;
        chk("reset_state", {bus.m_axi_arvalid, bus.m_axi_rready, bus.m_cmd_axis_tvalid,
                            bus.m_cmd_axis_tlast, busy, done, error}, 7'd0);
        @(negedge aclk);
        resetn = 1'b1;

        run_xfer(AW'(32'h100), 5, -1, 1, 0);
        run_xfer(AW'(32'h0), 40, -1, 0, 1);
        run_xfer(AW'(32'hFF8), 4, -1, 0, 0);
        tr_mode = 2;
        run_xfer(AW'(32'h300), 8, -1, 0, 0);
        tr_mode = 1;
        run_xfer(AW'(32'h500), 6, 2, 0, 0);
        run_xfer(AW'(32'h600), 3, -1, 0, 0);
        run_xfer(AW'(32'h700), 0, -1, 0, 0);
        run_xfer(AW'(32'h1FF_FFF8), 6, -1, 0, 0);
        reset_mid_burst();
        run_xfer(AW'(32'h40), 5, -1, 1, 0);

        for (int n = 0; n < 15; n++) begin
            int wc, eb;
            logic [AW-1:0] ra;
            tr_mode = int'($urandom_range(2));
            ar_rate = int'($urandom_range(100, 30));
            r_rate  = int'($urandom_range(100, 30));
            ra = AW'($urandom);
            wc = int'($urandom_range(50));
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(wc)) : -1;
            run_xfer(ra, wc, eb, 0, 0);
        end
        tr_mode = 1; ar_rate = 100; r_rate = 100;
        run_xfer(AW'(32'hFC0), 33, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_stream_dma.md
CMD_STREAM_DMA -- requirements
Module: cmd_stream_dma

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI read data width and command stream width in bits.
REQ-002 Parameter ADDR_WIDTH, default 25: AXI byte address width.
REQ-003 Parameter ID_WIDTH, default 8: AXI ID width; arid is driven constant 0.
REQ-004 Parameter MAX_BURST_LEN, default 16: maximum beats per AXI read burst, a power of two from 1 to 256.
REQ-005 Parameter LEN_WIDTH, default 16: width of the transfer word count.
REQ-006 aclk  in  1  single clock; all logic is rising-edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-009 src_addr  in  ADDR_WIDTH  byte address of the command buffer; low log2(DATA_WIDTH/8) bits ignored.
REQ-010 word_count  in  LEN_WIDTH  number of DATA_WIDTH words to fetch.
REQ-011 busy  out  1  high from the cycle after an accepted start until completion.
REQ-012 done  out  1  one-cycle pulse at completion.
REQ-013 error  out  1  sticky flag: some beat returned rresp != OKAY; cleared by the next accepted start.
REQ-014 m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  per AXI4  read address channel; size = log2(DATA_WIDTH/8), burst = INCR, lock/cache/prot = 0.
REQ-015 m_axi_arready  in  1  read address handshake.
REQ-016 m_axi_r{id,data,resp,last,valid}  in  per AXI4  read data channel; rid ignored.
REQ-017 m_axi_rready  out  1  read data handshake.
REQ-018 m_cmd_axis_{tvalid,tlast,tdata}  out  1/1/DATA_WIDTH  command stream output; m_cmd_axis_tready in 1.

Function
REQ-019 FSM states: IDLE, ADDR, DATA. Only one burst is outstanding at a time.
REQ-020 IDLE + start with word_count != 0: latch the aligned address and the remaining count, clear error, go to ADDR, and assert busy next cycle.
REQ-021 IDLE + start with word_count == 0: pulse done the next cycle; no AXI traffic, no stream beat, busy stays low.
REQ-022 ADDR: arvalid high with arlen = beats - 1, where beats = min(remaining, MAX_BURST_LEN, words remaining before the next 4 KiB boundary).
REQ-023 ADDR: arvalid, araddr and arlen are held stable until arready; on the handshake go to DATA, advance the address by beats*bytes and subtract beats from remaining.
REQ-024 DATA: each beat accepted on R (rvalid & rready) is pushed into the output skid buffer; rready = skid not full.
REQ-025 DATA: the accepted beat carrying rlast moves the FSM to ADDR if remaining != 0, otherwise to IDLE.
REQ-026 tlast is high only on the final word of the whole transfer, never on intermediate burst ends.
REQ-027 done pulses in the cycle the final word is accepted on the stream (tvalid & tready & tlast); busy falls in the same cycle.
REQ-028 rresp != 0 on any beat sets error; the data is still forwarded and the transfer continues.
REQ-029 Throughput: with tready held high, one word per cycle within a burst, plus the address phase between bursts.
REQ-030 Stream stalls (tready low) do not lose or duplicate words; tdata/tlast are held stable while tvalid & !tready.
REQ-031 start while busy is ignored.
REQ-032 Address wrap at 2^ADDR_WIDTH is modulo; no error is signalled.

Reset
REQ-033 While resetn is low: FSM = IDLE; arvalid, rready, tvalid, tlast, busy, done and error are 0; the skid buffer is empty.
REQ-034 Reset asserted mid-transfer aborts immediately; after release, no stale stream beat is emitted. A burst left outstanding on the bus is the system's responsibility.

Structure
REQ-035 The FSM state encoding, AXI constants (BURST_INCR, RESP_OKAY) and the 4 KiB boundary constant are defined in the shared package rrx_axi_pkg.
REQ-036 A single sub-module, cmd_dma_skid: a 2-entry skid buffer carrying {tlast, tdata}, with registered valid/ready on both sides.

Verification
REQ-037 start, src_addr=0x100, word_count=5, tready=1 -> one AR with addr 0x100 and len 4; 5 stream words in 5 consecutive cycles, tlast on word 5; done on word 5; error=0.
REQ-038 word_count=40, MAX_BURST_LEN=16 -> AR lens 15, 15, 7 at addrs 0x0, 0x40, 0x80; exactly one tlast, on word 40.
REQ-039 src_addr=0xFF8, word_count=4 -> AR len 1 at 0xFF8, then AR len 1 at 0x1000 (boundary split); 4 words in order.
REQ-040 word_count=8, tready toggled 1-0-1-0 -> data order preserved, no word lost or duplicated, rready deasserts while the skid is full.
REQ-041 Slave returns rresp=2 on beat 3 of 6 -> all 6 words forwarded, error=1 after beat 3, done pulses; next start clears error.
REQ-042 word_count=0 -> done pulses one cycle later, no arvalid; separately, resetn low mid-burst -> all outputs 0 within the reset, IDLE on release.
